// File: rtl/ble_cmd_receiver.sv
// BLE UART receive path: 2-flop sync, 8N1 receiver, 7-byte command frame parser and link watchdog.
// Outputs update one clock after the checksum stop-bit sample; no backpressure, the serial stream cannot stall.
module ble_cmd_receiver #(
  parameter int CLKS_PER_BIT   = 868,
  parameter int GAP_CYCLES     = 20 * 868,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       uart_rx,
  output logic [8:0] dir_degrees,
  output logic [9:0] target_speed,
  output logic       run_en,
  output logic       cmd_valid,
  output logic       frame_err,
  output logic       link_timeout
);

  localparam int BW = $clog2(CLKS_PER_BIT + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [BW-1:0] HALF_M1 = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] FULL_M1 = BW'(CLKS_PER_BIT - 1);
  localparam logic [GW-1:0] GAP_M1  = GW'(GAP_CYCLES - 1);
  localparam logic [WW-1:0] WD_M1   = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [WW-1:0] WD_MAX  = WW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {U_IDLE, U_START, U_DATA, U_STOP, U_BREAK} uart_state_t;
  typedef enum logic [2:0] {P_HUNT, P_DHI, P_DLO, P_SHI, P_SLO, P_FLG, P_CHK} parse_state_t;

  logic          rx_meta, rx_s;
  uart_state_t   u_state, u_next;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_dat;
  logic          byte_done, stop_bad;
  logic          byte_vld;
  logic [7:0]    byte_dat;

  parse_state_t  p_state, p_next;
  logic [7:0]    dhi, dlo, shi, slo, csum_run;
  logic          flag_run;
  logic [GW-1:0] gap_cnt;
  logic [WW-1:0] wd_cnt;
  logic          gap_hit, accept, reject;
  logic [15:0]   dir_full, spd_full;

  // Idle-high reset value keeps the receiver from seeing a start bit out of reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_s    <= rx_meta;
    end
  end

  always_comb begin
    u_next    = u_state;
    byte_done = 1'b0;
    stop_bad  = 1'b0;
    case (u_state)
      U_IDLE:  if (!rx_s) u_next = U_START;
      U_START: if (baud_cnt == HALF_M1) u_next = rx_s ? U_IDLE : U_DATA;
      U_DATA:  if (baud_cnt == FULL_M1 && bit_cnt == 3'd7) u_next = U_STOP;
      U_STOP: begin
        if (baud_cnt == FULL_M1) begin
          if (rx_s) begin
            byte_done = 1'b1;
            u_next    = U_IDLE;
          end else begin
            stop_bad = 1'b1;
            u_next   = U_BREAK;
          end
        end
      end
      U_BREAK: if (rx_s) u_next = U_IDLE;
      default: u_next = U_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      u_state   <= U_IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_dat <= '0;
      byte_vld  <= 1'b0;
      byte_dat  <= '0;
    end else begin
      u_state  <= u_next;
      byte_vld <= byte_done;
      if (byte_done) byte_dat <= shift_dat;
      if (u_state == U_IDLE) begin
        baud_cnt <= '0;
        bit_cnt  <= '0;
      end else if (u_state == U_START && baud_cnt == HALF_M1) begin
        baud_cnt <= '0;
      end else if (baud_cnt == FULL_M1) begin
        baud_cnt <= '0;
        if (u_state == U_DATA) begin
          shift_dat <= {rx_s, shift_dat[7:1]};
          bit_cnt   <= bit_cnt + 3'd1;
        end
      end else begin
        baud_cnt <= baud_cnt + BW'(1);
      end
    end
  end

  assign dir_full = {dhi, dlo};
  assign spd_full = {shi, slo};
  assign gap_hit  = (p_state != P_HUNT) && !byte_vld && (gap_cnt == GAP_M1);

  always_comb begin
    p_next = p_state;
    accept = 1'b0;
    reject = 1'b0;
    if (stop_bad) begin
      p_next = P_HUNT;
    end else if (byte_vld) begin
      case (p_state)
        P_HUNT: if (byte_dat == 8'hA5) p_next = P_DHI;
        P_DHI:  p_next = P_DLO;
        P_DLO:  p_next = P_SHI;
        P_SHI:  p_next = P_SLO;
        P_SLO:  p_next = P_FLG;
        P_FLG:  p_next = P_CHK;
        P_CHK: begin
          if (byte_dat == csum_run && dir_full < 16'd360 && spd_full <= 16'd1023) accept = 1'b1;
          else reject = 1'b1;
          p_next = P_HUNT;
        end
        default: p_next = P_HUNT;
      endcase
    end else if (gap_hit) begin
      p_next = P_HUNT;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      p_state  <= P_HUNT;
      dhi      <= '0;
      dlo      <= '0;
      shi      <= '0;
      slo      <= '0;
      flag_run <= 1'b0;
      csum_run <= '0;
      gap_cnt  <= '0;
    end else begin
      p_state <= p_next;
      if (byte_vld || p_state == P_HUNT || gap_hit) gap_cnt <= '0;
      else gap_cnt <= gap_cnt + GW'(1);
      if (byte_vld) begin
        case (p_state)
          P_DHI: begin dhi <= byte_dat; csum_run <= byte_dat; end
          P_DLO: begin dlo <= byte_dat; csum_run <= csum_run ^ byte_dat; end
          P_SHI: begin shi <= byte_dat; csum_run <= csum_run ^ byte_dat; end
          P_SLO: begin slo <= byte_dat; csum_run <= csum_run ^ byte_dat; end
          P_FLG: begin flag_run <= byte_dat[0]; csum_run <= csum_run ^ byte_dat; end
          default: ;
        endcase
      end
    end
  end

  // Saturating watchdog: parks at WD_MAX after firing so it pulses only once per accepted frame.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dir_degrees  <= '0;
      target_speed <= '0;
      run_en       <= 1'b0;
      cmd_valid    <= 1'b0;
      frame_err    <= 1'b0;
      link_timeout <= 1'b0;
      wd_cnt       <= '0;
    end else begin
      cmd_valid    <= accept;
      frame_err    <= stop_bad | reject | gap_hit;
      link_timeout <= 1'b0;
      if (accept) begin
        dir_degrees  <= dir_full[8:0];
        target_speed <= spd_full[9:0];
        run_en       <= flag_run;
        wd_cnt       <= '0;
      end else if (wd_cnt == WD_M1) begin
        wd_cnt       <= WD_MAX;
        run_en       <= 1'b0;
        link_timeout <= 1'b1;
      end else if (wd_cnt != WD_MAX) begin
        wd_cnt <= wd_cnt + WW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ble_cmd_receiver.sv
// Scoreboarded bench for ble_cmd_receiver: directed frames push expected events, a negedge monitor pops and compares.
module tb_ble_cmd_receiver;
  localparam int CPB = 8;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       uart_rx = 1'b1;
  logic [8:0] dir_degrees;
  logic [9:0] target_speed;
  logic       run_en, cmd_valid, frame_err, link_timeout;

  // kind encoding matches {link_timeout, frame_err, cmd_valid}
  localparam int EV_CMD = 1;
  localparam int EV_ERR = 2;
  localparam int EV_TMO = 4;

  typedef struct {int kind; int dir; int spd; int run;} exp_t;
  exp_t exp_q[$];
  int total = 0;
  int bad = 0;

  ble_cmd_receiver #(
    .CLKS_PER_BIT(CPB),
    .GAP_CYCLES(200),
    .TIMEOUT_CYCLES(2000)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .uart_rx(uart_rx),
    .dir_degrees(dir_degrees),
    .target_speed(target_speed),
    .run_en(run_en),
    .cmd_valid(cmd_valid),
    .frame_err(frame_err),
    .link_timeout(link_timeout)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic expect_ev(input int kind, input int dir, input int spd, input int run);
    exp_t e;
    e.kind = kind; e.dir = dir; e.spd = spd; e.run = run;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
  endtask

  task automatic send_byte(input logic [7:0] b);
    uart_rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      idle(CPB);
    end
    uart_rx = 1'b1;
    idle(CPB);
    idle(4);
  endtask

  task automatic send_frame(input logic [55:0] f);
    for (int i = 0; i < 7; i++) send_byte(f[55 - 8*i -: 8]);
    idle(10);
  endtask

  // Monitor: every output pulse must match the oldest pending expectation.
  initial begin
    exp_t e;
    int act;
    forever begin
      @(negedge clock);
      if (reset_n && (cmd_valid || frame_err || link_timeout)) begin
        act = int'({link_timeout, frame_err, cmd_valid});
        if (exp_q.size() == 0) begin
          check("unexpected_event", act, 0);
        end else begin
          e = exp_q.pop_front();
          check("event_kind", act, e.kind);
          check("dir_degrees", int'(dir_degrees), e.dir);
          check("target_speed", int'(target_speed), e.spd);
          check("run_en", int'(run_en), e.run);
        end
      end
    end
  end

  initial begin
    idle(5);
    @(negedge clock);
    check("rst_dir", int'(dir_degrees), 0);
    check("rst_spd", int'(target_speed), 0);
    check("rst_run", int'(run_en), 0);
    check("rst_cmd_valid", int'(cmd_valid), 0);
    check("rst_frame_err", int'(frame_err), 0);
    check("rst_link_timeout", int'(link_timeout), 0);
    reset_n = 1'b1;
    idle(10);

    // good frame: 270 deg, speed 512, run
    expect_ev(EV_CMD, 270, 512, 1);
    send_frame(56'hA5_01_0E_02_00_01_0C);

    // silence: one timeout pulse, direction/speed held, then no second pulse
    expect_ev(EV_TMO, 270, 512, 0);
    idle(2100);
    idle(4000);

    // 0xA5 inside a frame is plain data
    expect_ev(EV_CMD, 165, 165, 1);
    send_frame(56'hA5_00_A5_00_A5_01_01);

    // bad checksum
    expect_ev(EV_ERR, 165, 165, 1);
    send_frame(56'hA5_00_5A_00_64_01_00);

    // boundary values 359 / 1023 accepted
    expect_ev(EV_CMD, 359, 1023, 1);
    send_frame(56'hA5_01_67_03_FF_03_99);

    // direction 360 rejected
    expect_ev(EV_ERR, 359, 1023, 1);
    send_frame(56'hA5_01_68_00_10_01_78);

    expect_ev(EV_CMD, 100, 300, 1);
    send_frame(56'hA5_00_64_01_2C_01_48);

    expect_ev(EV_CMD, 0, 0, 0);
    send_frame(56'hA5_00_00_00_00_00_00);

    // speed 1024 rejected
    expect_ev(EV_ERR, 0, 0, 0);
    send_frame(56'hA5_00_64_04_00_01_61);

    // short low glitch: no byte, no error
    uart_rx = 1'b0;
    idle(2);
    uart_rx = 1'b1;
    idle(20);

    // partial frame then silence: gap error
    expect_ev(EV_ERR, 0, 0, 0);
    send_byte(8'hA5);
    send_byte(8'h00);
    idle(250);

    expect_ev(EV_CMD, 270, 512, 1);
    send_frame(56'hA5_01_0E_02_00_01_0C);

    // reset during data bits of byte 3
    send_byte(8'hA5);
    send_byte(8'h01);
    uart_rx = 1'b0;
    idle(CPB);
    uart_rx = 1'b0; idle(CPB);
    uart_rx = 1'b1; idle(CPB);
    uart_rx = 1'b1; idle(CPB);
    uart_rx = 1'b1; idle(3);
    reset_n = 1'b0;
    #1;
    check("midrst_dir", int'(dir_degrees), 0);
    check("midrst_spd", int'(target_speed), 0);
    check("midrst_run", int'(run_en), 0);
    check("midrst_pulses", int'({link_timeout, frame_err, cmd_valid}), 0);
    idle(20);
    @(negedge clock);
    reset_n = 1'b1;
    idle(20);

    expect_ev(EV_CMD, 100, 300, 1);
    send_frame(56'hA5_00_64_01_2C_01_48);

    idle(50);
    check("pending_expectations", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
